iop_queue: RTL and testbench
============================

# iop_queue

Micro-op issue queue between the front end's decode stage and the execute stage. It accepts decoded micro-ops (`id_iop`, `id_iop_init`, `id_arg`) from the front end under the `id_feed_req` / `ex_feed_slot` handshake and presents them in order to execute. It flushes on a pipeline redirect and tracks outstanding status-flag writers so the front end can see pending flag hazards.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; a power of 2 and ≥ 2.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `a_rst`  in  1  reset, synchronous and active-low.
- `id_feed_req`  in  1  front end offers a micro-op this cycle.
- `id_iop`  in  32  micro-op word; bit 21 = writes status flags.
- `id_iop_init`  in  3  initial micro-step index.
- `id_arg`  in  16  operand / immediate.
- `ex_feed_slot`  out  1  queue can accept an entry this cycle.
- `ex_valid`  out  1  head entry valid.
- `ex_iop`  out  32  head micro-op; 0 when empty.
- `ex_iop_init`  out  3  head micro-step; 0 when empty.
- `ex_arg`  out  16  head argument; 0 when empty.
- `ex_pop`  in  1  execute consumes the head entry.
- `ex_flush`  in  1  discard all entries (taken branch or PC write).
- `q_sf_pending`  out  1  at least one queued entry has `iop[21]` set.
- `q_count`  out  CW  current occupancy.

## Operation
- Storage is a circular buffer with read pointer `rp`, write pointer `wp` and counter `cnt`. Both pointers wrap modulo DEPTH.
- `ex_feed_slot = a_rst & (cnt < DEPTH)`. It is combinational from registered state and does not depend on `ex_pop`.
- A push occurs when `id_feed_req & ex_feed_slot`. The entry is written at `wp`, and `wp` increments.
- A pop occurs when `ex_pop & ex_valid`. `rp` increments. `ex_pop` while empty is ignored.
- `ex_valid = (cnt != 0)`. The head outputs are the contents at `rp`, gated to 0 when `ex_valid` is 0.
- Count update: +1 on push only, −1 on pop only, unchanged when both occur.
- Flag tracking: counter `sfc` (CW bits) increments on a push with `id_iop[21]=1`. It decrements on a pop whose head has `ex_iop[21]=1`. Both in the same cycle leaves it unchanged. `q_sf_pending = (sfc != 0)`.
- Flush: when `ex_flush=1`, `rp`, `wp`, `cnt` and `sfc` all go to 0. Any push or pop in that cycle is discarded. Flush has priority over everything except reset.
- Reset (`a_rst=0` at a clock edge): `rp=wp=cnt=sfc=0`, so the registered outputs are `ex_valid=0`, `q_count=0`, `q_sf_pending=0` and the head outputs are 0. While `a_rst` is low, `ex_feed_slot` is forced to 0. Stored payload is not cleared.

## Timing
- Push-to-visible latency is 1 cycle. There is no bypass: an entry pushed into an empty queue asserts `ex_valid` on the next cycle.
- Pop takes effect at the edge. The next head is visible in the following cycle.
- Full (`cnt=DEPTH`): `ex_feed_slot=0` for the whole cycle, even if `ex_pop=1`. A freed slot is offered the cycle after the pop, so full throughput is 1 entry per cycle only while `cnt < DEPTH`.
- Empty with push and pop in the same cycle: the pop is ignored and `cnt` becomes 1.
- Flush in cycle N: `ex_valid=0` and `ex_feed_slot=1` in cycle N+1. A push can land in N+1.
- Reset release: `ex_feed_slot=1` in the first cycle with `a_rst=1`.
- Pointer wrap: write at index DEPTH−1 is followed by index 0, with no bubble.

## Test plan
- Reset, then push 3 entries (`iop` = 0x11, 0x22, 0x33, `arg` = 0xA001..0xA003) on consecutive cycles with no pop. Required: `q_count` = 1, 2, 3; `ex_iop` = 0x11 from the cycle after the first push; `ex_feed_slot=1` throughout.
- Fill DEPTH=4 while holding `ex_pop=1` in the full cycle. Required: `ex_feed_slot=0` during the full cycle; pops return entries in push order; after 6 pushes and pops with wrap, data still matches.
- Push an entry with `iop[21]=1` (0x0020_0000) and one plain entry, then pop both. Required: `q_sf_pending=1` until the cycle after the flag entry is popped, then 0.
- With 3 entries queued, assert `ex_flush` together with `id_feed_req` and `ex_pop`. Required next cycle: `q_count=0`, `ex_valid=0`, `ex_iop=0`, `q_sf_pending=0`, and the flushed-cycle push does not appear.
- With 2 entries queued, pull `a_rst` low for 1 cycle. Required: `ex_feed_slot=0` during reset; afterwards `ex_valid=0`, `q_count=0`, `ex_feed_slot=1`.
- Empty queue with `id_feed_req=1` and `ex_pop=1` in the same cycle. Required: `q_count=1` and `ex_valid=1` next cycle with the pushed data.

Source files
------------

// File: rtl/iop_queue_if.sv
// iop_queue_if: decode/execute handshake bundle for the micro-op issue queue.
//   slave  : the queue itself (takes front-end micro-ops, presents the head to execute)
//   master : the front end / execute side driving requests, pops and flushes
//   CW     : width of the occupancy count q_count
interface iop_queue_if #(
  parameter int CW = 3
);
  logic          id_feed_req;
  logic [31:0]   id_iop;
  logic [2:0]    id_iop_init;
  logic [15:0]   id_arg;
  logic          ex_feed_slot;
  logic          ex_valid;
  logic [31:0]   ex_iop;
  logic [2:0]    ex_iop_init;
  logic [15:0]   ex_arg;
  logic          ex_pop;
  logic          ex_flush;
  logic          q_sf_pending;
  logic [CW-1:0] q_count;

  modport slave (
    input  id_feed_req, id_iop, id_iop_init, id_arg, ex_pop, ex_flush,
    output ex_feed_slot, ex_valid, ex_iop, ex_iop_init, ex_arg, q_sf_pending, q_count
  );

  modport master (
    output id_feed_req, id_iop, id_iop_init, id_arg, ex_pop, ex_flush,
    input  ex_feed_slot, ex_valid, ex_iop, ex_iop_init, ex_arg, q_sf_pending, q_count
  );
endinterface

// File: rtl/iop_queue.sv
// iop_queue: in-order micro-op issue queue between decode and execute.
//   clk   : single clock, rising edge
//   a_rst : synchronous active-low reset
//   bus   : iop_queue_if slave modport
//           id_*        - micro-op offered by decode (id_iop[21] = writes status flags)
//           ex_feed_slot- queue can take an entry this cycle
//           ex_*        - head entry presented to execute (zero when empty), ex_pop consumes it
//           ex_flush    - discards every entry (redirect)
//           q_sf_pending- some queued entry writes status flags
//           q_count     - occupancy
module iop_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        a_rst,
  iop_queue_if.slave  bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem_iop  [DEPTH];
  logic [2:0]    mem_init [DEPTH];
  logic [15:0]   mem_arg  [DEPTH];

  logic [AW-1:0] rp, wp;
  logic [CW-1:0] cnt, sfc;

  logic feed_slot, valid, push, pop, sf_inc, sf_dec;

  // Slot offer is based on registered occupancy only, so a pop in the full
  // cycle frees a slot for the following cycle, not this one.
  assign feed_slot = a_rst & (cnt < FULL);
  assign valid     = (cnt != '0);
  assign push      = bus.id_feed_req & feed_slot;
  assign pop       = bus.ex_pop & valid;
  assign sf_inc    = push & bus.id_iop[21];
  assign sf_dec    = pop & mem_iop[rp][21];

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      sfc <= '0;
    end else if (bus.ex_flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      sfc <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
      if (sf_inc && !sf_dec)      sfc <= sfc + CW'(1);
      else if (sf_dec && !sf_inc) sfc <= sfc - CW'(1);
    end
  end

  // Payload storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !bus.ex_flush) begin
      mem_iop[wp]  <= bus.id_iop;
      mem_init[wp] <= bus.id_iop_init;
      mem_arg[wp]  <= bus.id_arg;
    end
  end

  assign bus.ex_feed_slot = feed_slot;
  assign bus.ex_valid     = valid;
  assign bus.ex_iop       = valid ? mem_iop[rp]  : '0;
  assign bus.ex_iop_init  = valid ? mem_init[rp] : '0;
  assign bus.ex_arg       = valid ? mem_arg[rp]  : '0;
  assign bus.q_sf_pending = (sfc != '0);
  assign bus.q_count      = cnt;
endmodule

// File: tb/tb_iop_queue.sv
// tb_iop_queue: directed scoreboard bench for iop_queue (DEPTH=4).
module tb_iop_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [31:0] iop;
    logic [2:0]  init;
    logic [15:0] arg;
  } ent_t;

  logic clk;
  logic a_rst;
  int   n_assert;
  int   n_fail;
  ent_t sbq[$];

  iop_queue_if #(.CW(CW)) bus();

  iop_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_sf();
    logic r;
    r = 1'b0;
    foreach (sbq[i]) if (sbq[i].iop[21]) r = 1'b1;
    return r;
  endfunction

  // Compare all registered-state outputs with the model.
  task automatic chk_state(input string tag);
    ent_t head;
    head = '0;
    if (sbq.size() != 0) head = sbq[0];
    chk({tag, ".q_count"},  64'(bus.q_count), 64'(sbq.size()));
    chk({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'(sbq.size() != 0));
    chk({tag, ".sf_pend"},  64'(bus.q_sf_pending), 64'(model_sf()));
    chk({tag, ".head"},     64'({bus.ex_iop, bus.ex_iop_init, bus.ex_arg}), 64'(head));
  endtask

  // One clock cycle of stimulus; inputs applied away from the edge.
  task automatic do_cycle(input string tag, input logic push, input logic [31:0] iop,
                          input logic [2:0] init, input logic [15:0] arg,
                          input logic pop, input logic flush);
    ent_t e;
    logic acc, popv;
    e = '{iop: iop, init: init, arg: arg};
    bus.id_feed_req = push;
    bus.id_iop      = iop;
    bus.id_iop_init = init;
    bus.id_arg      = arg;
    bus.ex_pop      = pop;
    bus.ex_flush    = flush;
    #1;
    acc  = push && (sbq.size() < DEPTH);
    popv = pop && (sbq.size() != 0);
    chk({tag, ".feed_slot"}, 64'(bus.ex_feed_slot), 64'(sbq.size() < DEPTH));
    if (popv)
      chk({tag, ".pop_data"}, 64'({bus.ex_iop, bus.ex_iop_init, bus.ex_arg}), 64'(sbq[0]));
    @(posedge clk);
    #1;
    if (flush) sbq.delete();
    else begin
      if (popv) void'(sbq.pop_front());
      if (acc)  sbq.push_back(e);
    end
    bus.id_feed_req = 1'b0;
    bus.ex_pop      = 1'b0;
    bus.ex_flush    = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    a_rst    = 1'b0;
    bus.id_feed_req = 1'b0;
    bus.id_iop      = '0;
    bus.id_iop_init = '0;
    bus.id_arg      = '0;
    bus.ex_pop      = 1'b0;
    bus.ex_flush    = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.feed_slot", 64'(bus.ex_feed_slot), 64'(0));
    chk_state("rst");
    a_rst = 1'b1;
    #1;
    chk("rst_rel.feed_slot", 64'(bus.ex_feed_slot), 64'(1));

    // Three pushes back to back
    do_cycle("push1", 1, 32'h11, 3'd1, 16'hA001, 0, 0);
    do_cycle("push2", 1, 32'h22, 3'd2, 16'hA002, 0, 0);
    do_cycle("push3", 1, 32'h33, 3'd3, 16'hA003, 0, 0);

    // Fill, then push+pop while full: push must be refused
    do_cycle("fill4", 1, 32'h44, 3'd4, 16'hA004, 0, 0);
    do_cycle("fullpop", 1, 32'hDEAD, 3'd7, 16'hBEEF, 1, 0);
    for (int i = 0; i < 6; i++)
      do_cycle("wrap", 1, 32'h100 + 32'(i), 3'(i), 16'hB000 + 16'(i), 1, 0);
    while (sbq.size() != 0) do_cycle("drain", 0, 0, 0, 0, 1, 0);

    // Status-flag writer tracking
    do_cycle("sf_push", 1, 32'h0020_0000, 3'd5, 16'hC001, 0, 0);
    do_cycle("sf_plain", 1, 32'h55, 3'd6, 16'hC002, 0, 0);
    do_cycle("sf_pop1", 0, 0, 0, 0, 1, 0);
    do_cycle("sf_pop2", 0, 0, 0, 0, 1, 0);

    // Flush with concurrent push and pop
    do_cycle("fl_a", 1, 32'h61, 3'd1, 16'hD001, 0, 0);
    do_cycle("fl_b", 1, 32'h0020_0062, 3'd2, 16'hD002, 0, 0);
    do_cycle("fl_c", 1, 32'h63, 3'd3, 16'hD003, 0, 0);
    do_cycle("flush", 1, 32'h99, 3'd7, 16'hD099, 1, 1);
    do_cycle("fl_after", 1, 32'h77, 3'd4, 16'hD077, 0, 0);
    do_cycle("fl_pop", 0, 0, 0, 0, 1, 0);

    // Reset with entries queued
    do_cycle("rq_a", 1, 32'h81, 3'd1, 16'hE001, 0, 0);
    do_cycle("rq_b", 1, 32'h0020_0082, 3'd2, 16'hE002, 0, 0);
    a_rst = 1'b0;
    #1;
    chk("rq.feed_slot_low", 64'(bus.ex_feed_slot), 64'(0));
    @(posedge clk);
    #1;
    sbq.delete();
    a_rst = 1'b1;
    #1;
    chk("rq.feed_slot_rel", 64'(bus.ex_feed_slot), 64'(1));
    chk_state("rq_after");

    // Empty queue: push and pop in the same cycle
    do_cycle("emp_pp", 1, 32'h0AB, 3'd6, 16'hF00D, 1, 0);
    do_cycle("emp_pop", 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
